// File: rtl/ship_sprite_engine.sv
// Player ship sprite: two-stage per-pixel colour pipeline plus a small FSM that
// moves the ship once per frame, only while the raster is in vertical blanking.

module ship_sprite_engine #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned SHIP_W     = 16,
  parameter int unsigned SHIP_H     = 16,
  parameter int unsigned START_X    = 312,
  parameter int unsigned START_Y    = 232,
  parameter int unsigned MAX_SPEED  = 4,
  parameter logic [23:0] SHIP_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic        active_pixels,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        pause,
  output logic [23:0] rgb_out,
  output logic [9:0]  ship_x,
  output logic [9:0]  ship_y,
  output logic        frame_tick
);

  localparam logic [9:0]  START_X10 = 10'(START_X);
  localparam logic [9:0]  START_Y10 = 10'(START_Y);
  localparam logic [9:0]  Y_LAST    = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  Y_BLANK   = 10'(V_ACTIVE);
  localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - SHIP_W);
  localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - SHIP_H);
  localparam logic [10:0] W11       = 11'(SHIP_W);
  localparam logic [10:0] H11       = 11'(SHIP_H);
  localparam logic [3:0]  SPD_CAP   = 4'(MAX_SPEED);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    UPD_X,
    UPD_Y
  } state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic [3:0] spd;
    logic       dir;
  } axis_t;

  typedef struct packed {
    logic left;
    logic right;
    logic up;
    logic down;
    logic hold;
  } cmd_t;

  localparam axis_t AX_RST = '{pos: START_X10, spd: 4'd0, dir: 1'b0};
  localparam axis_t AY_RST = '{pos: START_Y10, spd: 4'd0, dir: 1'b0};

  // One axis of motion; dir=1 means the positive direction. A reversal drops
  // the carried speed to zero before accelerating.
  function automatic axis_t step_axis(input axis_t cur, input logic req_neg,
                                      input logic req_pos, input logic hold,
                                      input logic [10:0] bound);
    axis_t             nxt;
    logic [3:0]        base;
    logic signed [10:0] sum;
    nxt  = cur;
    base = '0;
    sum  = '0;
    if (!hold) begin
      if (req_neg ^ req_pos) begin
        base    = (cur.dir == req_pos) ? cur.spd : 4'd0;
        nxt.spd = (base >= SPD_CAP) ? SPD_CAP : base + 4'd1;
        nxt.dir = req_pos;
        if (req_pos) begin
          sum = $signed({1'b0, cur.pos}) + $signed({7'd0, nxt.spd});
        end else begin
          sum = $signed({1'b0, cur.pos}) - $signed({7'd0, nxt.spd});
        end
        if (sum[10]) begin
          nxt.pos = '0;
        end else if (sum > $signed(bound)) begin
          nxt.pos = bound[9:0];
        end else begin
          nxt.pos = sum[9:0];
        end
      end else begin
        nxt.spd = '0;
      end
    end
    return nxt;
  endfunction

  logic [9:0]  y_prev_q;
  logic        frame_tick_q, frame_tick_d;
  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  axis_t       ax_q, ax_d;
  axis_t       ay_q, ay_d;
  logic [9:0]  s1_x_q, s1_y_q;
  logic        s1_act_q;
  logic [23:0] rgb_q, rgb_d;
  logic [10:0] dx, dy;
  logic        hit;

  // Edge on the row counter: fires once when the raster leaves the last visible row.
  assign frame_tick_d = (y_prev_q == Y_LAST) && (y_pixel == Y_BLANK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_prev_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      y_prev_q     <= y_pixel;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    case (state_q)
      IDLE: begin
        if (frame_tick_q) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        cmd_d   = '{left: move_left, right: move_right, up: move_up,
                    down: move_down, hold: pause};
        state_d = UPD_X;
      end
      UPD_X: begin
        ax_d    = step_axis(ax_q, cmd_q.left, cmd_q.right, cmd_q.hold, X_MAX);
        state_d = UPD_Y;
      end
      UPD_Y: begin
        ay_d    = step_axis(ay_q, cmd_q.up, cmd_q.down, cmd_q.hold, Y_MAX);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      ax_q    <= AX_RST;
      ay_q    <= AY_RST;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
    end
  end

  // Pixels left of / above the ship wrap to large values, so a plain compare suffices.
  assign dx  = {1'b0, s1_x_q} - {1'b0, ax_q.pos};
  assign dy  = {1'b0, s1_y_q} - {1'b0, ay_q.pos};
  assign hit = (dx < W11) && (dy < H11);

  always_comb begin
    rgb_d = 24'h000000;
    if (s1_act_q) begin
      rgb_d = hit ? SHIP_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_act_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      s1_x_q   <= x_pixel;
      s1_y_q   <= y_pixel;
      s1_act_q <= active_pixels;
      rgb_q    <= rgb_d;
    end
  end

  assign rgb_out    = rgb_q;
  assign ship_x     = ax_q.pos;
  assign ship_y     = ay_q.pos;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ship_sprite_engine.sv
// Self-checking bench for ship_sprite_engine: scoreboarded pixel stream plus a
// behavioural motion model checked around each vertical-blank update.

module tb_ship_sprite_engine;

  logic        clk;
  logic        rst;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        active_pixels;
  logic        move_left;
  logic        move_right;
  logic        move_up;
  logic        move_down;
  logic        pause;
  logic [23:0] rgb_out;
  logic [9:0]  ship_x;
  logic [9:0]  ship_y;
  logic        frame_tick;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] expQ[$];
  logic [1:0]  pipe = 2'b00;
  logic        lastDrive = 1'b0;

  int mX, mY, mSx, mSy, mDx, mDy;

  int offX[9] = '{-1, 0, 15, 16, 16, 0, 15, 8, 0};
  int offY[9] = '{0, 0, 15, 15, 0, -1, 16, 8, 0};
  int exp3[5] = '{313, 315, 318, 322, 326};

  ship_sprite_engine dut (
    .clk          (clk),
    .rst          (rst),
    .x_pixel      (x_pixel),
    .y_pixel      (y_pixel),
    .active_pixels(active_pixels),
    .move_left    (move_left),
    .move_right   (move_right),
    .move_up      (move_up),
    .move_down    (move_down),
    .pause        (pause),
    .rgb_out      (rgb_out),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .frame_tick   (frame_tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [23:0] expRgb(input int x, input int y, input bit act);
    bit inShip;
    inShip = (x >= mX) && (x < mX + 16) && (y >= mY) && (y < mY + 16);
    return (act && inShip) ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic modelReset();
    mX = 312; mY = 232; mSx = 0; mSy = 0; mDx = 0; mDy = 0;
  endtask

  task automatic modelAxis(inout int pos, inout int spd, inout int dir,
                           input logic negReq, input logic posReq,
                           input logic hold, input int bound);
    if (hold) return;
    if (negReq != posReq) begin
      if (dir != int'(posReq)) spd = 0;
      spd = (spd + 1 > 4) ? 4 : spd + 1;
      dir = int'(posReq);
      pos = posReq ? pos + spd : pos - spd;
      if (pos < 0) pos = 0;
      if (pos > bound) pos = bound;
    end else begin
      spd = 0;
    end
  endtask

  // Advance one clock; compare the pixel driven two clocks earlier.
  task automatic tick();
    logic [23:0] e;
    @(posedge clk);
    #1;
    pipe = {pipe[0], lastDrive};
    lastDrive = 1'b0;
    if (pipe[1]) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboardEmpty", 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("rgb", rgb_out, e);
      end
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit act);
    int wx, wy;
    wx = x & 1023;
    wy = y & 1023;
    tick();
    x_pixel       = wx[9:0];
    y_pixel       = wy[9:0];
    active_pixels = act;
    expQ.push_back(expRgb(wx, wy, act));
    lastDrive = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Rgb"}, rgb_out, 0);
    checkOutput({tag, "Tick"}, frame_tick, 0);
    checkOutput({tag, "ShipX"}, ship_x, 312);
    checkOutput({tag, "ShipY"}, ship_y, 232);
  endtask

  task automatic doResetPulse();
    #3 rst = 1'b0;
    #1;
    checkResetState("rstNow");
    pipe = 2'b00;
    lastDrive = 1'b0;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    checkResetState("rstHeld");
    @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic runFrame(input bit toggleDown, input bit finalDown);
    int nX, nY, nSx, nSy, nDx, nDy;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(mX + offX[k], mY + offY[k], k != 8);
      checkOutput("shipYActive", ship_y, mY);
      if (toggleDown && (k % 2 == 1)) move_down = ~move_down;
    end
    if (toggleDown) move_down = finalDown;
    applyStimulus(mX, 479, 1'b0);
    nX = mX; nSx = mSx; nDx = mDx;
    nY = mY; nSy = mSy; nDy = mDy;
    modelAxis(nX, nSx, nDx, move_left, move_right, pause, 624);
    modelAxis(nY, nSy, nDy, move_up, move_down, pause, 464);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(mX, 480, 1'b0);
      checkOutput("frameTick", frame_tick, i == 1);
      if (i == 3) checkOutput("shipXBeforeUpd", ship_x, mX);
      if (i == 4) checkOutput("shipYBeforeUpd", ship_y, mY);
      if (i == 8) begin
        checkOutput("shipXAfterUpd", ship_x, nX);
        checkOutput("shipYAfterUpd", ship_y, nY);
      end
    end
    mX = nX; mSx = nSx; mDx = nDx;
    mY = nY; mSy = nSy; mDy = nDy;
  endtask

  initial begin
    rst = 1'b0;
    x_pixel = 10'd100; y_pixel = 10'd5; active_pixels = 1'b1;
    move_left = 1'b0; move_right = 1'b0; move_up = 1'b0; move_down = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("powerOn");
    @(negedge clk);
    rst = 1'b1;
    modelReset();

    // Reset asserted in the middle of a visible line.
    applyStimulus(312, 232, 1'b1);
    applyStimulus(313, 232, 1'b1);
    doResetPulse();

    // Static ship rendering and first frame tick.
    runFrame(1'b0, 1'b0);
    checkOutput("idleShipX", ship_x, 312);

    $display("[TB] acceleration to the right");
    move_right = 1'b1;
    for (int f = 0; f < 5; f++) begin
      runFrame(1'b0, 1'b0);
      checkOutput("accelShipX", ship_x, exp3[f]);
      checkOutput("accelShipY", ship_y, 232);
    end

    $display("[TB] right clamp then reversal to the left clamp");
    for (int f = 0; f < 100 && mX < 624; f++) runFrame(1'b0, 1'b0);
    runFrame(1'b0, 1'b0);
    runFrame(1'b0, 1'b0);
    checkOutput("rightClamp", ship_x, 624);
    move_right = 1'b0;
    move_left  = 1'b1;
    runFrame(1'b0, 1'b0);
    checkOutput("reverseFirstMove", ship_x, 623);
    for (int f = 0; f < 200 && mX > 0; f++) runFrame(1'b0, 1'b0);
    runFrame(1'b0, 1'b0);
    checkOutput("leftClamp", ship_x, 0);

    $display("[TB] both held, restart, pause");
    move_right = 1'b1;
    runFrame(1'b0, 1'b0);
    checkOutput("bothHeld", ship_x, 0);
    move_left = 1'b0;
    runFrame(1'b0, 1'b0);
    checkOutput("restartMove", ship_x, 1);
    runFrame(1'b0, 1'b0);
    checkOutput("secondMove", ship_x, 3);
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      runFrame(1'b0, 1'b0);
      checkOutput("pausedX", ship_x, 3);
    end
    pause = 1'b0;
    runFrame(1'b0, 1'b0);
    checkOutput("resumeSpeedKept", ship_x, 6);
    move_right = 1'b0;

    $display("[TB] vertical motion with move_down toggling during active video");
    for (int f = 0; f < 100 && mY < 464; f++) runFrame(1'b1, 1'b1);
    runFrame(1'b1, 1'b1);
    checkOutput("bottomClamp", ship_y, 464);
    move_up = 1'b1;
    runFrame(1'b1, 1'b0);
    checkOutput("upReverse", ship_y, 463);
    move_up = 1'b0;

    $display("[TB] reset during the update sequence");
    move_right = 1'b1;
    applyStimulus(mX, 479, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mX, 480, 1'b0);
      checkOutput("midTick", frame_tick, i == 1);
    end
    doResetPulse();
    runFrame(1'b0, 1'b0);
    checkOutput("postResetMove", ship_x, 313);
    move_right = 1'b0;
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
